// File: rtl/cb_seq_pkg.sv
// rtl/cb_seq_pkg.sv - shared types, defaults and helpers for the L1A sequencer
`timescale 1ns/1ps
package cb_seq_pkg;

  localparam int CB_ADDR_W  = 9;
  localparam int CB_LAT_MIN = 2;
  localparam int CB_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/l1aStrobePipe.sv
// rtl/l1aStrobePipe.sv - 3-stage L1A strobe shifter, isolated so it can be triplicated
`timescale 1ns/1ps
module l1aStrobePipe (
  input  logic clk,
  input  logic rstn,
  input  logic i_flush,
  input  logic i_launch,
  output logic o_pre,
  output logic o_mid,
  output logic o_dly
);

  logic [2:0] r_stage;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stage <= '0;
    end else if (i_flush) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[1:0], i_launch};
    end
  end

  assign o_pre = r_stage[0];
  assign o_mid = r_stage[1];
  assign o_dly = r_stage[2];

endmodule

// File: rtl/cb_l1a_sequencer.sv
// rtl/cb_l1a_sequencer.sv - circular-buffer write/latency/L1A strobe sequencer
`timescale 1ns/1ps
module cb_l1a_sequencer
  import cb_seq_pkg::*;
#(
  parameter int ADDR_W  = CB_ADDR_W,
  parameter int LAT_MIN = CB_LAT_MIN,
  parameter int CNT_W   = CB_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] latencyIn,
  input  logic              l1aIn,
  input  logic              clrCnt,
  output logic              dis,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [ADDR_W-1:0] latencyL1A,
  output logic              L1APre,
  output logic              L1A,
  output logic              L1ADelay,
  output logic              ready,
  output logic              latErr,
  output logic [CNT_W-1:0]  l1aCount,
  output logic [CNT_W-1:0]  dropCount
);

  localparam logic [31:0] CNT_MAX = 32'((1 << CNT_W) - 1);

  seq_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [ADDR_W-1:0] r_fill_cnt, w_fill_nxt;
  logic [ADDR_W-1:0] r_lat, w_lat_nxt;
  logic              r_lat_err, w_lat_err_nxt;
  logic              r_dis, r_ready;
  logic [CNT_W-1:0]  r_l1a_cnt, r_drop_cnt;
  logic              w_lat_ok, w_accept, w_drop, w_flush, w_launch;

  // Upper bound is the full address range, so only the lower bound can fail.
  assign w_lat_ok = (latencyIn >= ADDR_W'(LAT_MIN));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_wr_addr  <= '0;
      r_fill_cnt <= '0;
      r_lat      <= '0;
      r_lat_err  <= 1'b0;
      r_dis      <= 1'b1;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_lat      <= w_lat_nxt;
      r_lat_err  <= w_lat_err_nxt;
      r_dis      <= (w_state_nxt == ST_IDLE);
      r_ready    <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_addr_nxt = r_wr_addr;
    w_fill_nxt    = r_fill_cnt;
    w_lat_nxt     = r_lat;
    w_lat_err_nxt = r_lat_err;
    w_accept      = 1'b0;
    w_drop        = 1'b0;
    w_flush       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wr_addr_nxt = '0;
        w_fill_nxt    = '0;
        w_lat_nxt     = latencyIn;
        if (enable) begin
          if (w_lat_ok) begin
            w_state_nxt   = ST_FILL;
            w_lat_err_nxt = 1'b0;
          end else begin
            w_lat_err_nxt = 1'b1;
          end
        end
      end
      ST_FILL: begin
        w_drop = l1aIn;
        if (!enable) begin
          w_state_nxt   = ST_IDLE;
          w_wr_addr_nxt = '0;
          w_fill_nxt    = '0;
          w_flush       = 1'b1;
        end else begin
          w_wr_addr_nxt = r_wr_addr + 1'b1;
          w_fill_nxt    = r_fill_cnt + 1'b1;
          if (r_fill_cnt == r_lat) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_accept = l1aIn;
        if (!enable) begin
          w_state_nxt   = ST_IDLE;
          w_wr_addr_nxt = '0;
          w_fill_nxt    = '0;
          w_flush       = 1'b1;
        end else begin
          w_wr_addr_nxt = r_wr_addr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A trigger coinciding with the run being dropped is counted but never strobed.
  assign w_launch = w_accept & ~w_flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_l1a_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (clrCnt) begin
      r_l1a_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) r_l1a_cnt <= CNT_W'(sat_inc(32'(r_l1a_cnt), CNT_MAX));
      if (w_drop)   r_drop_cnt <= CNT_W'(sat_inc(32'(r_drop_cnt), CNT_MAX));
    end
  end

  l1aStrobePipe u_strobe_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .i_flush  (w_flush),
    .i_launch (w_launch),
    .o_pre    (L1APre),
    .o_mid    (L1A),
    .o_dly    (L1ADelay)
  );

  assign dis        = r_dis;
  assign ready      = r_ready;
  assign wrAddr     = r_wr_addr;
  assign latencyL1A = r_lat;
  assign latErr     = r_lat_err;
  assign l1aCount   = r_l1a_cnt;
  assign dropCount  = r_drop_cnt;

endmodule

// File: tb/tb_cb_l1a_sequencer.sv
// tb/tb_cb_l1a_sequencer.sv - self-checking bench for cb_l1a_sequencer
`timescale 1ns/1ps
module tb_cb_l1a_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       enable, l1aIn, clrCnt;
  logic [8:0] latencyIn;
  logic       dis, L1APre, L1A, L1ADelay, ready, latErr;
  logic [8:0] wrAddr, latencyL1A;
  logic [7:0] l1aCount, dropCount;

  always #5 clk = ~clk;

  cb_l1a_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .latencyIn  (latencyIn),
    .l1aIn      (l1aIn),
    .clrCnt     (clrCnt),
    .dis        (dis),
    .wrAddr     (wrAddr),
    .latencyL1A (latencyL1A),
    .L1APre     (L1APre),
    .L1A        (L1A),
    .L1ADelay   (L1ADelay),
    .ready      (ready),
    .latErr     (latErr),
    .l1aCount   (l1aCount),
    .dropCount  (dropCount)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: run described by its start edge and latency, strobes by
  // the set of edges at which a trigger was launched and the last flush edge.
  int k = 0;
  bit m_active = 0;
  int m_e = 0, m_lat = 0, m_latl1a = 0;
  bit m_err = 0;
  int m_cnt = 0, m_drop = 0;
  int m_last_flush = -1;
  bit acc[int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, k);
    end
  endtask

  function automatic bit launched(input int j);
    return (j >= 0) && acc.exists(j) && (m_last_flush < j);
  endfunction

  task automatic check_all();
    chk("dis",        32'(dis),        32'(!m_active));
    chk("ready",      32'(ready),      32'(m_active && (k >= m_e + m_lat + 1)));
    chk("wrAddr",     32'(wrAddr),     m_active ? 32'((k - m_e) % 512) : 32'd0);
    chk("latencyL1A", 32'(latencyL1A), 32'(m_latl1a));
    chk("L1APre",     32'(L1APre),     32'(launched(k)));
    chk("L1A",        32'(L1A),        32'(launched(k - 1)));
    chk("L1ADelay",   32'(L1ADelay),   32'(launched(k - 2)));
    chk("latErr",     32'(latErr),     32'(m_err));
    chk("l1aCount",   32'(l1aCount),   32'(m_cnt));
    chk("dropCount",  32'(dropCount),  32'(m_drop));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    m_active = 0; m_latl1a = 0; m_err = 0; m_cnt = 0; m_drop = 0;
    m_last_flush = k;
    acc.delete();
    check_all();
    rstn = 1'b1;
  endtask

  task automatic step(input bit en, input int lat, input bit trig, input bit clr);
    int st;
    enable = en; latencyIn = lat[8:0]; l1aIn = trig; clrCnt = clr;
    @(posedge clk);
    k++;
    st = !m_active ? 0 : (k <= m_e + m_lat + 1) ? 1 : 2;
    if (st == 0) begin
      m_latl1a = lat;
      if (en) begin
        if (lat >= 2) begin
          m_active = 1; m_e = k; m_lat = lat; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (!en) begin
      m_active = 0;
      m_last_flush = k;
    end
    if (trig && st == 1) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
    if (trig && st == 2) begin
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      if (en) acc[k] = 1'b1;
    end
    if (clr) begin
      m_cnt = 0; m_drop = 0;
    end
    #1;
    check_all();
  endtask

  function automatic int rlat();
    return int'($urandom_range(0, 511));
  endfunction

  initial begin
    enable = 1'b0; l1aIn = 1'b0; clrCnt = 1'b0; latencyIn = '0;
    #1;
    do_reset();

    for (int i = 0; i < 3; i++) step(0, rlat(), 1'($urandom_range(0, 1)), 0);

    // Enable with latency 5; triggers inside FILL and on the FILL->RUN edge.
    step(1, 5, 0, 0);
    chk("dis_fall", 32'(dis), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      step(1, rlat(), (i == 2) || (i == 6), 0);
      if (i == 5) chk("ready_early", 32'(ready), 32'd0);
    end
    chk("ready_entry", 32'(ready), 32'd1);
    chk("wrAddr_entry", 32'(wrAddr), 32'd6);
    chk("drop_two", 32'(dropCount), 32'd2);
    chk("acc_zero", 32'(l1aCount), 32'd0);

    // Single accepted trigger.
    step(1, rlat(), 1, 0);
    chk("pre_t1", 32'(L1APre), 32'd1);
    step(1, rlat(), 0, 0);
    chk("l1a_t2", 32'(L1A), 32'd1);
    step(1, rlat(), 0, 0);
    chk("dly_t3", 32'(L1ADelay), 32'd1);
    chk("acc_one", 32'(l1aCount), 32'd1);
    step(0, rlat(), 0, 0);

    // Illegal then legal latency.
    step(1, 1, 0, 0);
    chk("laterr_set", 32'(latErr), 32'd1);
    chk("dis_bad", 32'(dis), 32'd1);
    step(1, 200, 0, 0);
    chk("laterr_clr", 32'(latErr), 32'd0);

    // Long run with random triggers, address wrap and a back-to-back burst.
    for (int i = 0; i < 600; i++) begin
      bit t;
      t = ($urandom_range(0, 5) == 0);
      if (i >= 400 && i <= 402) t = 1'b1;
      step(1, rlat(), t, (i == 100));
      if (i == 402) begin
        chk("burst_pre", 32'(L1APre), 32'd1);
        chk("burst_l1a", 32'(L1A), 32'd1);
        chk("burst_dly0", 32'(L1ADelay), 32'd1);
      end
      if (i == 403 || i == 404) chk("burst_dly", 32'(L1ADelay), 32'd1);
    end

    // Drop enable one cycle after a trigger.
    step(1, rlat(), 1, 0);
    step(0, rlat(), 0, 0);
    chk("flush_l1a", 32'(L1A), 32'd0);
    chk("flush_dis", 32'(dis), 32'd1);
    chk("flush_addr", 32'(wrAddr), 32'd0);

    // Saturation of the accepted counter.
    step(0, rlat(), 0, 1);
    step(1, 3, 0, 0);
    for (int i = 0; i < 4; i++) step(1, rlat(), 0, 0);
    for (int i = 0; i < 300; i++) step(1, rlat(), 1, 0);
    chk("sat_255", 32'(l1aCount), 32'd255);

    // Asynchronous reset with strobes in flight.
    step(1, rlat(), 1, 0);
    do_reset();
    chk("rst_pre", 32'(L1APre), 32'd0);

    // Clear beats increment in the same cycle.
    step(1, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(1, rlat(), 0, 0);
    step(1, rlat(), 1, 1);
    chk("clr_prio", 32'(l1aCount), 32'd0);
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 15) != 0), int'($urandom_range(0, 20)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
